// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared widths and index/data types for the round-robin arbiter
package rr_arb_pkg;
    localparam int N_SRC  = 4;
    localparam int DATA_W = 4;
    typedef logic [1:0]        src_idx_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/rr_arb_4_1_if.sv
// rr_arb_4_1_if: producer-side valid/ready bundle and registered output bus
interface rr_arb_4_1_if;
    import rr_arb_pkg::*;
    logic [N_SRC-1:0]  in_valid;
    data_t [N_SRC-1:0] in_data;
    logic [N_SRC-1:0]  in_ready;
    logic              out_valid;
    logic              out_ready;
    data_t             out_data;
    src_idx_t          out_sel;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/mux_4_1.sv
// mux_4_1: 4-bit 4:1 multiplexer; only the selected input reaches y
module mux_4_1 (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    always_comb y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/rr_pick_4.sv
// rr_pick_4: circular first-valid search starting at ptr
module rr_pick_4 import rr_arb_pkg::*; (
    input  logic [N_SRC-1:0] in_valid,
    input  src_idx_t         ptr,
    output src_idx_t         gnt_idx,
    output logic             any_valid
);
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    src_idx_t           off;
    always_comb begin
        dbl       = {in_valid, in_valid} >> ptr;
        rot       = dbl[N_SRC-1:0];
        off       = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        gnt_idx   = ptr + off;
        any_valid = |in_valid;
    end
endmodule

// File: rtl/rr_arb_4_1.sv
// rr_arb_4_1: registered round-robin 4:1 arbiter feeding a single-entry output stage
module rr_arb_4_1 import rr_arb_pkg::*; (
    input logic         clk,
    input logic         rst_n,
    rr_arb_4_1_if.slave bus
);
    logic     out_valid_q, out_valid_d;
    data_t    out_data_q, out_data_d;
    src_idx_t out_sel_q, out_sel_d;
    src_idx_t ptr_q, ptr_d;
    src_idx_t gnt_idx;
    logic     any_valid, load, xfer;
    data_t    mux_y;

    rr_pick_4 u_pick (.in_valid(bus.in_valid), .ptr(ptr_q), .gnt_idx(gnt_idx), .any_valid(any_valid));

    mux_4_1 u_mux (
        .d0(bus.in_data[0]), .d1(bus.in_data[1]), .d2(bus.in_data[2]), .d3(bus.in_data[3]),
        .sel(gnt_idx), .y(mux_y)
    );

    always_comb begin
        load        = !out_valid_q || bus.out_ready;
        xfer        = load && any_valid;
        out_valid_d = load ? any_valid : out_valid_q;
        out_data_d  = xfer ? mux_y : out_data_q;
        out_sel_d   = xfer ? gnt_idx : out_sel_q;
        ptr_d       = xfer ? gnt_idx + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    // no grant is advertised while reset is held, even though the stage looks empty
    assign bus.in_ready  = (xfer && rst_n) ? N_SRC'(1) << gnt_idx : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_4_1.sv
// tb_rr_arb_4_1: table-driven vectors with a scoreboard queue for granted payloads
module tb_rr_arb_4_1;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    rr_arb_4_1_if bus ();
    rr_arb_4_1 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [15:0] d;
        logic        ordy;
        logic [3:0]  rdy;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] sb[$];
    int         pass_cnt = 0;
    int         total = 0;
    logic       exp_v = 0;
    logic [1:0] exp_s = 0;
    logic [3:0] exp_d = 0;

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        else pass_cnt++;
    endtask

    function automatic logic [1:0] oh2i(logic [3:0] oh);
        logic [1:0] r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        bus.in_valid = 4'hF;
        bus.in_data = 16'hDCBA;
        bus.out_ready = 1;
        #1;
        chk("rst_out_valid", 16'(bus.out_valid), 0);
        chk("rst_out_sel", 16'(bus.out_sel), 0);
        chk("rst_out_data", 16'(bus.out_data), 0);
        chk("rst_in_ready", 16'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1;
        bus.in_valid = 0;
        exp_v = 0;
        sb.delete();
    endtask

    task automatic step(vec_t t);
        logic       load;
        logic       pushed;
        logic [1:0] g;
        if (t.rst) do_reset();
        @(negedge clk);
        bus.in_valid = t.v;
        bus.in_data = t.d;
        bus.out_ready = t.ordy;
        #1;
        chk("in_ready", 16'(bus.in_ready), 16'(t.rdy));
        load = !exp_v || t.ordy;
        pushed = 0;
        if (t.rdy != 0) begin
            g = oh2i(t.rdy);
            sb.push_back({g, t.d[4*g +: 4]});
            pushed = 1;
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            {exp_s, exp_d} = sb.pop_front();
            exp_v = 1;
        end else if (load) exp_v = 0;
        chk("out_valid", 16'(bus.out_valid), 16'(exp_v));
        if (exp_v) begin
            chk("out_sel", 16'(bus.out_sel), 16'(exp_s));
            chk("out_data", 16'(bus.out_data), 16'(exp_d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.out_ready = 0;
        // reset then full rotation over all four sources, no bubbles
        tbl.push_back('{1'b1, 4'hF, 16'hDCBA, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'b1000});
        tbl.push_back('{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'b0001});
        // alternating sources 1 and 3
        tbl.push_back('{1'b1, 4'b1010, 16'h9876, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b1010, 16'h9876, 1'b1, 4'b1000});
        tbl.push_back('{1'b0, 4'b1010, 16'h9876, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b1010, 16'h9876, 1'b1, 4'b1000});
        // back-pressure for 5 cycles, then grant resumes at ptr+1
        tbl.push_back('{1'b1, 4'hF, 16'hDCBA, 1'b1, 4'b0001});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 4'hF, 16'hDCBA, 1'b0, 4'b0000});
        tbl.push_back('{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'h0, 16'hDCBA, 1'b1, 4'b0000});
        // single request, bubble, then search from ptr=3 favours source 0
        tbl.push_back('{1'b1, 4'b0100, 16'h0700, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 16'h0700, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 16'h0700, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0011, 16'h0021, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 16'h0021, 1'b1, 4'b0000});
        // unknown payload on an idle source must stay isolated
        tbl.push_back('{1'b1, 4'b0111, 16'hx321, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b0111, 16'hx321, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b0111, 16'hx321, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b0111, 16'hx321, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b0111, 16'hx321, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b0111, 16'hx321, 1'b1, 4'b0100});
        foreach (tbl[i]) step(tbl[i]);

        // asynchronous reset between edges while the output stage is full
        step('{1'b1, 4'b0010, 16'h0050, 1'b1, 4'b0010});
        #2;
        rst_n = 0;
        #1;
        chk("async_out_valid", 16'(bus.out_valid), 0);
        chk("async_out_sel", 16'(bus.out_sel), 0);
        chk("async_out_data", 16'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1;
        bus.in_valid = 4'b0110;
        bus.in_data = 16'h0650;
        bus.out_ready = 1;
        #1;
        chk("post_rst_in_ready", 16'(bus.in_ready), 16'b0010);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 16'(bus.out_valid), 1);
        chk("post_rst_out_sel", 16'(bus.out_sel), 1);
        chk("post_rst_out_data", 16'(bus.out_data), 5);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
